// File: rtl/pipeline_if.sv
// Shared types for the pipeline controller: FSM state and per-latch controls.
package pipeline_if;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned DRAIN_W = 4;

  typedef enum logic [1:0] {
    RUN,
    DWAIT,
    DRAIN,
    HALTED
  } ctrl_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } latch_ctrl_t;

  typedef struct packed {
    latch_ctrl_t ifde;
    latch_ctrl_t deex;
    latch_ctrl_t exmem;
    latch_ctrl_t memwb;
  } pipe_ctrl_t;

  // Same enable/flush pair applied to every pipeline latch.
  function automatic pipe_ctrl_t pipe_all(input logic en, input logic flush);
    latch_ctrl_t l;
    l.en    = en;
    l.flush = flush;
    return '{ifde: l, deex: l, exmem: l, memwb: l};
  endfunction

endpackage

// File: rtl/perf_counter.sv
// 32-bit free-running event counter with synchronous clear and freeze.
module perf_counter
  import pipeline_if::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_freeze,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count qualified events; natural modulo-2^32 wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_inc && !i_freeze) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard / stall / halt controller for a 5-stage pipeline.
module pipeline_ctrl
  import pipeline_if::*;
#(
  parameter int unsigned DRAIN_CYCLES = 1
)
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic        mem_halt,
  input  logic        ex_memren,
  input  logic [4:0]  ex_regdest,
  input  logic [4:0]  de_rs,
  input  logic [4:0]  de_rt,
  input  logic        ex_br_taken,
  input  logic        de_jump,
  output logic        pc_en,
  output logic        ifde_en,
  output logic        deex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifde_flush,
  output logic        deex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        halt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  ctrl_state_t        r_state;
  ctrl_state_t        w_next;
  logic [DRAIN_W-1:0] r_drain;
  logic               r_halt;
  pipe_ctrl_t         w_ctl;
  logic               w_pc_en;
  logic               w_dstall;
  logic               w_loaduse;
  logic               w_drain_load;
  logic               w_stall_inc;
  logic               w_flush_inc;
  logic               w_freeze;

  // Next state and latch controls, evaluated in rule-priority order.
  always_comb begin
    w_next       = r_state;
    w_pc_en      = 1'b1;
    w_ctl        = pipe_all(1'b1, 1'b0);
    w_dstall     = 1'b0;
    w_drain_load = 1'b0;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    w_loaduse    = ex_memren && (ex_regdest != '0) &&
                   ((ex_regdest == de_rs) || (ex_regdest == de_rt));
    if (RST) begin
      w_next  = RUN;
      w_pc_en = 1'b0;
      w_ctl   = pipe_all(1'b0, 1'b1);
    end else begin
      case (r_state)
        HALTED: begin
          w_pc_en = 1'b0;
          w_ctl   = pipe_all(1'b0, 1'b0);
        end
        DRAIN: begin
          w_pc_en          = 1'b0;
          w_ctl            = pipe_all(1'b0, 1'b1);
          w_ctl.memwb      = '{en: 1'b1, flush: 1'b0};
          if (r_drain <= DRAIN_W'(1)) w_next = HALTED;
        end
        default: begin
          // RUN and DWAIT share the hazard rules; DWAIT only waits on dhit.
          w_dstall = (r_state == DWAIT) ? !dhit : ((mem_ren || mem_wen) && !dhit);
          if (w_dstall) begin
            w_next            = DWAIT;
            w_pc_en           = 1'b0;
            w_ctl.ifde.en     = 1'b0;
            w_ctl.deex.en     = 1'b0;
            w_ctl.exmem.en    = 1'b0;
            w_ctl.memwb.flush = 1'b1;
          end else begin
            w_next = RUN;
            if (mem_halt) begin
              w_next       = DRAIN;
              w_drain_load = 1'b1;
              w_pc_en      = 1'b0;
              w_ctl        = pipe_all(1'b0, 1'b1);
              w_ctl.memwb  = '{en: 1'b1, flush: 1'b0};
            end else if (ex_br_taken) begin
              w_ctl.ifde.flush = 1'b1;
              w_ctl.deex.flush = 1'b1;
              w_flush_inc      = 1'b1;
            end else if (w_loaduse) begin
              w_pc_en          = 1'b0;
              w_ctl.ifde.en    = 1'b0;
              w_ctl.deex.flush = 1'b1;
            end else if (de_jump) begin
              w_ctl.ifde.flush = 1'b1;
              w_flush_inc      = 1'b1;
            end else if (!ihit) begin
              w_pc_en          = 1'b0;
              w_ctl.ifde.flush = 1'b1;
            end
          end
          w_stall_inc = !w_pc_en;
        end
      endcase
    end
  end

  // State, drain countdown and sticky halt flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= RUN;
      r_halt  <= 1'b0;
      r_drain <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == HALTED) r_halt <= 1'b1;
      if (w_drain_load) begin
        r_drain <= DRAIN_W'(DRAIN_CYCLES);
      end else if ((r_state == DRAIN) && (r_drain != '0)) begin
        r_drain <= r_drain - 1'b1;
      end
    end
  end

  assign w_freeze = (r_state == DRAIN) || (r_state == HALTED);

  perf_counter u_stall_cnt (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_inc    (w_stall_inc),
    .i_freeze (w_freeze),
    .o_cnt    (stall_cnt)
  );

  perf_counter u_flush_cnt (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_inc    (w_flush_inc),
    .i_freeze (w_freeze),
    .o_cnt    (flush_cnt)
  );

  assign pc_en       = w_pc_en;
  assign ifde_en     = w_ctl.ifde.en;
  assign deex_en     = w_ctl.deex.en;
  assign exmem_en    = w_ctl.exmem.en;
  assign memwb_en    = w_ctl.memwb.en;
  assign ifde_flush  = w_ctl.ifde.flush;
  assign deex_flush  = w_ctl.deex.flush;
  assign exmem_flush = w_ctl.exmem.flush;
  assign memwb_flush = w_ctl.memwb.flush;
  assign halt        = r_halt;

endmodule
